// File: rtl/switch_sequencer.sv
// Table-driven switch sequencer: plays up to MAX_STEPS {code, dwell} entries per pass,
// repeating a latched number of passes (0 = forever), with abort and a one-cycle done pulse.
module switch_sequencer #(
    parameter int MAX_STEPS = 8,
    parameter int OUT_W     = 2,
    parameter int DWELL_W   = 17,
    parameter int REPEAT_W  = 16,
    localparam int AW       = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
    localparam int NW       = $clog2(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [OUT_W-1:0]    cfg_out,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [NW-1:0]       n_steps,
    input  logic [REPEAT_W-1:0] n_repeats,
    output logic [OUT_W-1:0]    out,
    output logic [AW-1:0]       step,
    output logic                step_strobe,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [OUT_W-1:0]    code_mem_r  [MAX_STEPS];
    logic [DWELL_W-1:0]  dwell_mem_r [MAX_STEPS];

    logic [OUT_W-1:0]    out_r, out_s;
    logic [AW-1:0]       step_r, step_s;
    logic                strobe_r, strobe_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [DWELL_W-1:0]  dwell_cnt_r, dwell_cnt_s;
    logic [NW-1:0]       nsteps_r, nsteps_s;
    logic [REPEAT_W-1:0] nrep_r, nrep_s;
    logic [REPEAT_W-1:0] pass_r, pass_s;

    logic [NW-1:0]       nsteps_clamp_s;
    logic [AW-1:0]       step_inc_s;
    logic                last_step_s;

    // The dwell counter holds remaining cycles minus one, so a dwell of 0 behaves as 1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        if (d == {DWELL_W{1'b0}}) begin
            dwell_load = {DWELL_W{1'b0}};
        end else begin
            dwell_load = d - DWELL_W'(1);
        end
    endfunction

    assign step_inc_s  = step_r + AW'(1);
    assign last_step_s = (NW'(step_r) == (nsteps_r - NW'(1)));

    // Schedule table write port; frozen while a sequence is running, untouched by reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_r != ST_RUN) && (int'(cfg_addr) < MAX_STEPS)) begin
            code_mem_r[cfg_addr]  <= cfg_out;
            dwell_mem_r[cfg_addr] <= cfg_dwell;
        end
    end

    // Request length clamp to the table depth.
    always_comb begin
        nsteps_clamp_s = n_steps;
        if (n_steps > NW'(MAX_STEPS)) begin
            nsteps_clamp_s = NW'(MAX_STEPS);
        end else begin
            nsteps_clamp_s = n_steps;
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s     = state_r;
        out_s       = out_r;
        step_s      = step_r;
        strobe_s    = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        dwell_cnt_s = dwell_cnt_r;
        nsteps_s    = nsteps_r;
        nrep_s      = nrep_r;
        pass_s      = pass_r;
        case (state_r)
            ST_IDLE: begin
                out_s       = {OUT_W{1'b0}};
                step_s      = {AW{1'b0}};
                busy_s      = 1'b0;
                dwell_cnt_s = {DWELL_W{1'b0}};
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start && (n_steps != {NW{1'b0}})) begin
                    state_s     = ST_RUN;
                    nsteps_s    = nsteps_clamp_s;
                    nrep_s      = n_repeats;
                    pass_s      = n_repeats;
                    out_s       = code_mem_r[0];
                    dwell_cnt_s = dwell_load(dwell_mem_r[0]);
                    strobe_s    = 1'b1;
                    busy_s      = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s     = ST_IDLE;
                    out_s       = {OUT_W{1'b0}};
                    step_s      = {AW{1'b0}};
                    busy_s      = 1'b0;
                    dwell_cnt_s = {DWELL_W{1'b0}};
                end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
                    dwell_cnt_s = dwell_cnt_r - DWELL_W'(1);
                end else if (!last_step_s) begin
                    step_s      = step_inc_s;
                    out_s       = code_mem_r[step_inc_s];
                    dwell_cnt_s = dwell_load(dwell_mem_r[step_inc_s]);
                    strobe_s    = 1'b1;
                end else if ((nrep_r == {REPEAT_W{1'b0}}) || (pass_r > REPEAT_W'(1))) begin
                    // Wrap with no idle gap; infinite mode never touches the pass counter.
                    step_s      = {AW{1'b0}};
                    out_s       = code_mem_r[0];
                    dwell_cnt_s = dwell_load(dwell_mem_r[0]);
                    strobe_s    = 1'b1;
                    if (nrep_r != {REPEAT_W{1'b0}}) begin
                        pass_s = pass_r - REPEAT_W'(1);
                    end else begin
                        pass_s = pass_r;
                    end
                end else begin
                    state_s     = ST_DONE;
                    out_s       = {OUT_W{1'b0}};
                    step_s      = {AW{1'b0}};
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    dwell_cnt_s = {DWELL_W{1'b0}};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                out_s   = {OUT_W{1'b0}};
                step_s  = {AW{1'b0}};
                busy_s  = 1'b0;
            end
            default: begin
                state_s     = ST_IDLE;
                out_s       = {OUT_W{1'b0}};
                step_s      = {AW{1'b0}};
                busy_s      = 1'b0;
                dwell_cnt_s = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_r       <= {OUT_W{1'b0}};
            step_r      <= {AW{1'b0}};
            strobe_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dwell_cnt_r <= {DWELL_W{1'b0}};
            nsteps_r    <= {NW{1'b0}};
            nrep_r      <= {REPEAT_W{1'b0}};
            pass_r      <= {REPEAT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            out_r       <= out_s;
            step_r      <= step_s;
            strobe_r    <= strobe_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            dwell_cnt_r <= dwell_cnt_s;
            nsteps_r    <= nsteps_s;
            nrep_r      <= nrep_s;
            pass_r      <= pass_s;
        end
    end

    assign out         = out_r;
    assign step        = step_r;
    assign step_strobe = strobe_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed self-checking bench for switch_sequencer: inputs driven and outputs sampled on negedge.
module tb_switch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [1:0]  cfg_out;
    logic [16:0] cfg_dwell;
    logic [3:0]  n_steps;
    logic [15:0] n_repeats;
    logic [1:0]  out;
    logic [2:0]  step;
    logic        step_strobe;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    switch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_out     (cfg_out),
        .cfg_dwell   (cfg_dwell),
        .n_steps     (n_steps),
        .n_repeats   (n_repeats),
        .out         (out),
        .step        (step),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_entry(input logic [2:0] a, input logic [1:0] c, input logic [16:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_out = c; cfg_dwell = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_addr = 3'd0; cfg_out = 2'd0; cfg_dwell = 17'd0; n_steps = 4'd0; n_repeats = 16'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out, step, step_strobe, busy, done} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {out, step, step_strobe, busy, done}, 8'd0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Table {0:(1,3),1:(2,2)}, 2 steps, 1 pass; vector = {out,step,strobe,busy,done}.
    task automatic run_basic(input string tag, input bit mid_write);
        logic [7:0] exp_v [7];
        exp_v = '{8'b01_000_1_1_0, 8'b01_000_0_1_0, 8'b01_000_0_1_0, 8'b10_001_1_1_0,
                  8'b10_001_0_1_0, 8'b00_000_0_0_1, 8'b00_000_0_0_0};
        n_steps = 4'd2; n_repeats = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_steps = 4'd5; n_repeats = 16'd7;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({out, step, step_strobe, busy, done} !== exp_v[c]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, c,
                         {out, step, step_strobe, busy, done}, exp_v[c]);
            end
            if (mid_write && c == 1) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_out = 2'd3; cfg_dwell = 17'd1;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_basic();
        write_entry(3'd0, 2'd1, 17'd3);
        write_entry(3'd1, 2'd2, 17'd2);
        run_basic("basic", 1'b0);
    endtask

    task automatic test_wrap();
        int nb, ns, nd, both;
        nb = 0; ns = 0; nd = 0; both = 0;
        n_steps = 4'd2; n_repeats = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy) nb++;
            if (step_strobe) ns++;
            if (done) nd++;
            if (done && step_strobe) both++;
            @(negedge clk);
        end
        checks++;
        if (nb != 15) begin errors++; $display("FAIL wrap_busy: got %0d expected 15", nb); end
        checks++;
        if (ns != 6) begin errors++; $display("FAIL wrap_strobe: got %0d expected 6", ns); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL wrap_done: got %0d expected 1", nd); end
        checks++;
        if (both != 0) begin errors++; $display("FAIL wrap_done_strobe: got %0d expected 0", both); end
    endtask

    task automatic test_zero_dwell();
        logic [7:0] ev;
        write_entry(3'd0, 2'd1, 17'd0);
        write_entry(3'd1, 2'd2, 17'd0);
        write_entry(3'd2, 2'd3, 17'd0);
        n_steps = 4'd3; n_repeats = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ev = {2'((c % 3) + 1), 3'(c % 3), 1'b1, 1'b1, 1'b0};
            checks++;
            if ({out, step, step_strobe, busy, done} !== ev) begin
                errors++;
                $display("FAIL zero_dwell cycle %0d: got %b expected %b", c,
                         {out, step, step_strobe, busy, done}, ev);
            end
            if (c < 29) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({out, step, step_strobe, busy, done} !== 8'd0) begin
                errors++;
                $display("FAIL abort cycle %0d: got %b expected %b", c,
                         {out, step, step_strobe, busy, done}, 8'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored();
        n_steps = 4'd0; n_repeats = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_steps busy cycle %0d: got %b expected 0", c, busy);
            end
            @(negedge clk);
        end
        write_entry(3'd0, 2'd1, 17'd3);
        write_entry(3'd1, 2'd2, 17'd2);
        run_basic("write_in_run", 1'b1);
        run_basic("table_after_write", 1'b0);
    endtask

    task automatic test_clamp();
        logic [7:0] ev;
        for (int i = 0; i < 8; i++) write_entry(3'(i), 2'(i), 17'd1);
        n_steps = 4'd9; n_repeats = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) ev = {2'(c), 3'(c), 1'b1, 1'b1, 1'b0};
            else if (c == 8) ev = 8'b00_000_0_0_1;
            else ev = 8'd0;
            checks++;
            if ({out, step, step_strobe, busy, done} !== ev) begin
                errors++;
                $display("FAIL clamp cycle %0d: got %b expected %b", c,
                         {out, step, step_strobe, busy, done}, ev);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_abort();
        n_steps = 4'd2; n_repeats = 16'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({out, step_strobe, busy, done} !== 5'd0) begin
                errors++;
                $display("FAIL start_abort cycle %0d: got %b expected %b", c,
                         {out, step_strobe, busy, done}, 5'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        write_entry(3'd0, 2'd1, 17'd3);
        write_entry(3'd1, 2'd2, 17'd2);
        n_steps = 4'd2; n_repeats = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out, step, step_strobe} !== 6'b10_001_1) begin
            errors++;
            $display("FAIL midrun_step1: got %b expected %b", {out, step, step_strobe}, 6'b10_001_1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({out, step, step_strobe, busy, done} !== 8'd0) begin
                errors++;
                $display("FAIL midrun_reset cycle %0d: got %b expected %b", c,
                         {out, step, step_strobe, busy, done}, 8'd0);
            end
            @(negedge clk);
        end
        run_basic("replay_after_reset", 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_dwell();
        test_ignored();
        test_clamp();
        test_start_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
